// File: rtl/fifo_slave.sv
// Bus-mapped FIFO: the bus pushes and peeks words, and the engine side pops them.
// Optional sticky overflow/underflow flags are enabled with the FIFO_SLAVE_ERR_EN macro.
module fifo_slave #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              S_sel,
    input  logic              S_wr,
    input  logic [7:0]        S_address,
    input  logic [DATA_W-1:0] S_din,
    output logic [DATA_W-1:0] S_dout,
    input  logic              pop_req,
    output logic [DATA_W-1:0] pop_data,
    output logic              pop_valid,
    output logic              f_interrupt
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr_reg, rd_ptr_reg;
    logic [CW-1:0]     count_reg;
    logic [4:0]        thresh_reg;
    logic [DATA_W-1:0] s_dout_reg, pop_data_reg;
    logic              pop_valid_reg, f_int_reg;

    logic              bus_wr, bus_rd, wr_data, wr_clear;
    logic              is_empty, is_full, do_pop, do_push, push_drop, pop_empty;
    logic              thr_hit, err_int, ovf, unf;
    logic [1:0]        int_en_rd;
    logic [4:0]        count5;
    logic [DATA_W-1:0] head_word, status_word, rd_word;

    assign bus_wr    = S_sel & S_wr;
    assign bus_rd    = S_sel & ~S_wr;
    assign wr_data   = bus_wr && (S_address == 8'h00);
    assign wr_clear  = bus_wr && (S_address == 8'h03);
    assign is_empty  = (count_reg == '0);
    assign is_full   = (count_reg == CW'(DEPTH));
    // A flush wins over any push or pop in the same cycle.
    assign do_pop    = pop_req & ~is_empty & ~wr_clear;
    assign do_push   = wr_data & (~is_full | do_pop) & ~wr_clear;
    assign push_drop = wr_data & is_full & ~do_pop & ~wr_clear;
    assign pop_empty = pop_req & is_empty & ~wr_clear;
    assign count5    = 5'(count_reg);
    assign thr_hit   = (count5 >= thresh_reg) && (thresh_reg != 5'd0);
    assign head_word = mem[rd_ptr_reg];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= S_din;
        end
    end

`ifdef FIFO_SLAVE_ERR_EN
    logic [1:0] int_en_reg;
    logic       ovf_reg, unf_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            int_en_reg <= 2'b00;
            ovf_reg    <= 1'b0;
            unf_reg    <= 1'b0;
        end else begin
            if (bus_wr && (S_address == 8'h02)) begin
                int_en_reg <= S_din[1:0];
            end
            if (wr_clear) begin
                ovf_reg <= 1'b0;
                unf_reg <= 1'b0;
            end else begin
                if (push_drop) ovf_reg <= 1'b1;
                if (pop_empty) unf_reg <= 1'b1;
            end
        end
    end

    assign int_en_rd = int_en_reg;
    assign ovf       = ovf_reg;
    assign unf       = unf_reg;
    assign err_int   = int_en_reg[1] & (ovf_reg | unf_reg);
`else
    logic int_en_reg;
    logic unused_err;

    always_ff @(posedge clk) begin
        if (reset) begin
            int_en_reg <= 1'b0;
        end else if (bus_wr && (S_address == 8'h02)) begin
            int_en_reg <= S_din[0];
        end
    end

    assign int_en_rd  = {1'b0, int_en_reg};
    assign ovf        = 1'b0;
    assign unf        = 1'b0;
    assign err_int    = 1'b0;
    assign unused_err = push_drop | pop_empty;
`endif

    always_comb begin
        status_word     = '0;
        status_word[4:0] = count5;
        status_word[8]  = is_empty;
        status_word[9]  = is_full;
        status_word[10] = thr_hit;
        status_word[11] = ovf;
        status_word[12] = unf;
    end

    always_comb begin
        rd_word = '0;
        case (S_address)
            8'h00:   rd_word = is_empty ? '0 : head_word;
            8'h01:   rd_word = status_word;
            8'h02:   rd_word = DATA_W'(int_en_rd);
            8'h04:   rd_word = DATA_W'(thresh_reg);
            default: rd_word = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            count_reg     <= '0;
            thresh_reg    <= 5'd0;
            s_dout_reg    <= '0;
            pop_data_reg  <= '0;
            pop_valid_reg <= 1'b0;
            f_int_reg     <= 1'b0;
        end else begin
            if (wr_clear) begin
                wr_ptr_reg <= '0;
                rd_ptr_reg <= '0;
                count_reg  <= '0;
            end else begin
                if (do_push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
                if (do_pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
                case ({do_push, do_pop})
                    2'b10:   count_reg <= count_reg + CW'(1);
                    2'b01:   count_reg <= count_reg - CW'(1);
                    default: count_reg <= count_reg;
                endcase
            end
            pop_valid_reg <= do_pop;
            if (do_pop) pop_data_reg <= head_word;
            if (bus_rd) s_dout_reg <= rd_word;
            if (bus_wr && (S_address == 8'h04)) thresh_reg <= S_din[4:0];
            f_int_reg <= (int_en_rd[0] & thr_hit) | err_int;
        end
    end

    assign S_dout      = s_dout_reg;
    assign pop_data    = pop_data_reg;
    assign pop_valid   = pop_valid_reg;
    assign f_interrupt = f_int_reg;
endmodule

// File: tb/tb_fifo_slave.sv
// Scoreboard bench for fifo_slave: stimulus queues expected bus reads and pops,
// and a negedge monitor compares them whenever the DUT presents a result.
module tb_fifo_slave;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 8;
`ifdef FIFO_SLAVE_ERR_EN
    localparam bit ERR = 1'b1;
`else
    localparam bit ERR = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset;
    logic              S_sel, S_wr, pop_req;
    logic [7:0]        S_address;
    logic [DATA_W-1:0] S_din, S_dout, pop_data;
    logic              pop_valid, f_interrupt;

    fifo_slave #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .S_sel(S_sel), .S_wr(S_wr),
        .S_address(S_address), .S_din(S_din), .S_dout(S_dout),
        .pop_req(pop_req), .pop_data(pop_data), .pop_valid(pop_valid),
        .f_interrupt(f_interrupt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [DATA_W-1:0] rd_q[$];
    logic [DATA_W-1:0] pop_q[$];
    logic rd_pend = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end else begin
            $display("ok   %s: 0x%0h", name, act);
        end
    endtask

    // Monitor: a read sampled at a posedge shows on S_dout by the following negedge.
    always @(posedge clk) rd_pend <= S_sel && !S_wr && !reset;

    always @(negedge clk) begin
        if (rd_pend) begin
            if (rd_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL read_unexpected: got 0x%0h expected no read", S_dout);
            end else begin
                check("bus_read", S_dout, rd_q.pop_front());
            end
        end
        if (pop_valid) begin
            if (pop_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL pop_unexpected: got 0x%0h expected no pop_valid", pop_data);
            end else begin
                check("pop_data", pop_data, pop_q.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [7:0] a, input logic [DATA_W-1:0] d);
        S_sel = 1'b1; S_wr = 1'b1; S_address = a; S_din = d;
        tick();
        S_sel = 1'b0; S_wr = 1'b0;
    endtask

    task automatic bus_read(input logic [7:0] a, input logic [DATA_W-1:0] exp);
        S_sel = 1'b1; S_wr = 1'b0; S_address = a;
        rd_q.push_back(exp);
        tick();
        S_sel = 1'b0;
    endtask

    task automatic do_pop(input logic [DATA_W-1:0] exp);
        pop_req = 1'b1;
        pop_q.push_back(exp);
        tick();
        pop_req = 1'b0;
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_s_dout"}, S_dout, 32'h0);
        check({tag, "_pop_data"}, pop_data, 32'h0);
        check({tag, "_pop_valid"}, {31'h0, pop_valid}, 32'h0);
        check({tag, "_f_interrupt"}, {31'h0, f_interrupt}, 32'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; S_sel = 1'b0; S_wr = 1'b0; S_address = 8'h00;
        S_din = '0; pop_req = 1'b0;
        tick(); tick();
        reset = 1'b0;
        check_outputs_zero("reset");
        bus_read(8'h01, 32'h100);
        bus_read(8'h02, 32'h0);
        bus_read(8'h04, 32'h0);

        // Four pushes, count then peek; S_dout holds while idle
        for (int i = 10; i <= 13; i++) bus_write(8'h00, i);
        bus_read(8'h01, 32'h004);
        tick();
        check("s_dout_hold", S_dout, 32'h004);
        bus_read(8'h00, 32'd10);
        for (int i = 10; i <= 13; i++) do_pop(i);
        tick();
        bus_read(8'h01, 32'h100);

        // Empty pop: no pulse, pop_data keeps the last word
        pop_req = 1'b1;
        tick();
        pop_req = 1'b0;
        check("empty_pop_valid", {31'h0, pop_valid}, 32'h0);
        check("empty_pop_data", pop_data, 32'd13);
        bus_read(8'h01, 32'h100 | (ERR ? 32'h1000 : 32'h0));
        bus_write(8'h03, 32'h0);
        bus_read(8'h01, 32'h100);
        bus_read(8'h00, 32'h0);
        bus_read(8'h03, 32'h0);
        bus_read(8'h07, 32'h0);

        // Fill, drop a push on full, then push+pop while full
        for (int i = 1; i <= 8; i++) bus_write(8'h00, i);
        bus_write(8'h00, 32'd99);
        bus_read(8'h01, 32'h208 | (ERR ? 32'h800 : 32'h0));
        bus_read(8'h00, 32'd1);
        S_sel = 1'b1; S_wr = 1'b1; S_address = 8'h00; S_din = 32'd20;
        pop_req = 1'b1; pop_q.push_back(32'd1);
        tick();
        S_sel = 1'b0; S_wr = 1'b0; pop_req = 1'b0;
        bus_read(8'h01, 32'h208 | (ERR ? 32'h800 : 32'h0));
        for (int i = 2; i <= 8; i++) do_pop(i);
        do_pop(32'd20);
        tick();
        bus_read(8'h01, 32'h100 | (ERR ? 32'h800 : 32'h0));
        bus_write(8'h03, 32'h0);

        // Threshold interrupt
        bus_write(8'h04, 32'd2);
        bus_write(8'h02, 32'd1);
        bus_read(8'h04, 32'd2);
        bus_read(8'h02, 32'd1);
        bus_write(8'h00, 32'd14);
        bus_write(8'h00, 32'd16);
        check("int_lag", {31'h0, f_interrupt}, 32'h0);
        tick();
        check("int_rise", {31'h0, f_interrupt}, 32'h1);
        bus_read(8'h01, 32'h402);
        do_pop(32'd14);
        check("int_hold_after_pop", {31'h0, f_interrupt}, 32'h1);
        tick();
        check("int_fall", {31'h0, f_interrupt}, 32'h0);
        do_pop(32'd16);
        tick();

        // CLEAR in the same cycle as a pop wins
        bus_write(8'h00, 32'd5);
        bus_write(8'h00, 32'd6);
        S_sel = 1'b1; S_wr = 1'b1; S_address = 8'h03; pop_req = 1'b1;
        tick();
        S_sel = 1'b0; S_wr = 1'b0; pop_req = 1'b0;
        check("clear_pop_valid", {31'h0, pop_valid}, 32'h0);
        bus_read(8'h01, 32'h100);

        // Reset mid-operation
        for (int i = 7; i <= 9; i++) bus_write(8'h00, i);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_outputs_zero("midreset");
        bus_read(8'h01, 32'h100);
        bus_read(8'h04, 32'h0);
        bus_read(8'h02, 32'h0);

        tick(); tick();
        check("rd_q_drained", rd_q.size(), 32'h0);
        check("pop_q_drained", pop_q.size(), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/fifo_slave.md
FIFO_SLAVE -- requirements
Module: fifo_slave

Interface
REQ-001 The block SHALL have one clock; reset is synchronous and active-high.
REQ-002 Parameter DATA_W, default 32, SHALL set the data word and bus data width.
REQ-003 Parameter DEPTH, default 8, SHALL set the FIFO entries; it SHALL be a power of 2, from 2 to 16.
REQ-004 clk  input  1  sole clock, rising edge.
REQ-005 reset  input  1  synchronous active-high reset.
REQ-006 S_sel  input  1  slave select from the bus arbiter.
REQ-007 S_wr  input  1  1 = write, 0 = read; valid only with S_sel.
REQ-008 S_address  input  8  register offset.
REQ-009 S_din  input  DATA_W  bus write data.
REQ-010 S_dout  output  DATA_W  registered bus read data.
REQ-011 pop_req  input  1  engine-side pop request.
REQ-012 pop_data  output  DATA_W  popped word, registered.
REQ-013 pop_valid  output  1  one-cycle pulse qualifying pop_data.
REQ-014 f_interrupt  output  1  level interrupt.

Function
REQ-015 Register map SHALL be fixed:
- 0x00 DATA: write pushes S_din; read peeks the head without popping, or returns 0 when empty.
- 0x01 STATUS, read-only: [4:0] count, [8] empty, [9] full, [10] thr_hit, [11] ovf, [12] unf.
- 0x02 INT_EN, R/W: [0] is the threshold enable.
- 0x03 CLEAR, write-only: any write flushes the FIFO and clears ovf/unf; reads return 0.
- 0x04 THRESH, R/W, [4:0].
REQ-016 Bus write SHALL occur in the cycle S_sel=1 and S_wr=1; unmapped addresses SHALL be ignored.
REQ-017 Bus read SHALL update S_dout one cycle after S_sel=1 and S_wr=0; an unmapped address SHALL return 0; S_dout SHALL hold its value when the bus is not reading.
REQ-018 A push to a full FIFO with no same-cycle pop SHALL be dropped without changing the contents.
REQ-019 pop_req with a non-empty FIFO SHALL drive pop_data to the head and pulse pop_valid on the next cycle; count SHALL decrement.
REQ-020 pop_req with an empty FIFO SHALL leave pop_valid at 0 and pop_data unchanged.
REQ-021 Push and pop in the same cycle SHALL both complete; count SHALL be unchanged; this SHALL be legal when full; when empty, only the push SHALL take effect.
REQ-022 Read and write pointers SHALL be log2(DEPTH) bits and wrap modulo DEPTH; count SHALL range from 0 to DEPTH.
REQ-023 thr_hit SHALL be (count >= THRESH) and (THRESH != 0), evaluated on the registered count.
REQ-024 f_interrupt SHALL be registered and equal (INT_EN[0] and thr_hit), plus the error term of REQ-031.
REQ-025 A CLEAR write in the same cycle as a push or pop SHALL win: the FIFO empties, and pop_valid stays 0 on the next cycle.
REQ-026 Push data SHALL be visible to a DATA peek or a pop one cycle after the write.

Reset
REQ-027 On reset, the pointers, count, INT_EN and THRESH SHALL be 0.
REQ-028 On reset, S_dout, pop_data, pop_valid, f_interrupt, ovf and unf SHALL be 0.
REQ-029 Reset mid-operation SHALL discard all FIFO contents; storage RAM need not be cleared.

Configuration
REQ-030 Macro FIFO_SLAVE_ERR_EN SHALL gate the error-flag logic.
REQ-031 With FIFO_SLAVE_ERR_EN defined:
- ovf sets sticky on a dropped push.
- unf sets sticky on an empty pop.
- INT_EN[1] is implemented, and f_interrupt additionally asserts on INT_EN[1] and (ovf or unf).
REQ-032 With FIFO_SLAVE_ERR_EN undefined, STATUS[12:11] and INT_EN[1] SHALL read 0, and no sticky flags SHALL be built.

Verification
REQ-033 Push 10, 11, 12, 13 to 0x00, then read 0x01 -> S_dout = 0x004 (count 4) on the following cycle.
REQ-034 Push 8 words, then push 99 -> STATUS = 0x208 (full, count 8); the 99 is dropped; with FIFO_SLAVE_ERR_EN, ovf = 1.
REQ-035 Write THRESH=2 and INT_EN=1, then push 14 and 16 -> f_interrupt rises one cycle after count reaches 2; one pop -> f_interrupt falls.
REQ-036 Fill to 8, then push 20 while pop_req=1 -> pop_data = the oldest word and count stays 8; draining pop order is words 2..8 then 20.
REQ-037 pop_req while empty -> pop_valid stays 0; with FIFO_SLAVE_ERR_EN, unf = 1 and a CLEAR write returns STATUS to 0x100.
REQ-038 Push 3 words, then assert reset for one cycle -> STATUS = 0x100, and all outputs are 0 on the next cycle.
